// File: rtl/multicycle_controller.sv
// Multicycle RISC-V style main controller FSM.
// Sequences fetch/decode/execute/memory/writeback for lw, sw, R-type,
// I-type ALU, beq and jal, and handshakes with a unified memory through
// mem_ready. Optional feature macro: MC_ILLEGAL_HALT_EN -- when defined, an
// unknown opcode parks the FSM in HALT with illegal=1 until reset; when
// undefined, unknown opcodes are dropped and the FSM refetches.
module multicycle_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       adr_src,
  output logic       mem_write,
  output logic       ir_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] imm_src,
  output logic       reg_write,
  output logic [1:0] alu_op,
  output logic       retire,
  output logic       illegal,
  output logic [3:0] state
);

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_ALUWB    = 4'd7,
    S_EXECUTEI = 4'd8,
    S_JAL      = 4'd9,
    S_BEQ      = 4'd10
`ifdef MC_ILLEGAL_HALT_EN
    ,
    S_HALT     = 4'd11
`endif
  } state_t;

  state_t state_q;
  state_t state_d;

  assign state = state_q;

  // State register; reset wins from any state, including mid-access and HALT.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

`ifdef MC_ILLEGAL_HALT_EN
  logic illegal_q;

  // Sticky illegal flag, raised on the edge that enters HALT.
  always_ff @(posedge clk) begin
    if (reset) begin
      illegal_q <= 1'b0;
    end else if (state_d == S_HALT) begin
      illegal_q <= 1'b1;
    end
  end

  assign illegal = illegal_q;
`else
  assign illegal = 1'b0;
`endif

  // Immediate format depends only on the opcode, so it is ready in DECODE.
  always_comb begin
    imm_src = 2'b00;
    case (op)
      OP_SW:   imm_src = 2'b01;
      OP_BEQ:  imm_src = 2'b10;
      OP_JAL:  imm_src = 2'b11;
      default: imm_src = 2'b00;
    endcase
  end

  // Next-state and per-state datapath controls; enables are masked by reset.
  always_comb begin
    state_d    = state_q;
    pc_write   = 1'b0;
    adr_src    = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    result_src = 2'b00;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    reg_write  = 1'b0;
    alu_op     = 2'b00;
    retire     = 1'b0;

    case (state_q)
      S_FETCH: begin
        // PC+4 is computed and written back the same cycle the instruction lands.
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        ir_write   = mem_ready;
        pc_write   = mem_ready;
        state_d    = mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        // Branch/jump target precomputed from old PC + immediate.
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECUTER;
          OP_I:         state_d = S_EXECUTEI;
          OP_BEQ:       state_d = S_BEQ;
          OP_JAL:       state_d = S_JAL;
`ifdef MC_ILLEGAL_HALT_EN
          default:      state_d = S_HALT;
`else
          default:      state_d = S_FETCH;
`endif
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        state_d   = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        adr_src = 1'b1;
        state_d = mem_ready ? S_MEMWB : S_MEMREAD;
      end
      S_MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
        retire     = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWRITE: begin
        // Write strobe held until the memory accepts; retire on acceptance.
        adr_src   = 1'b1;
        mem_write = 1'b1;
        retire    = mem_ready;
        state_d   = mem_ready ? S_FETCH : S_MEMWRITE;
      end
      S_EXECUTER: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b10;
        state_d   = S_ALUWB;
      end
      S_EXECUTEI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = 2'b10;
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        retire    = 1'b1;
        state_d   = S_FETCH;
      end
      S_JAL: begin
        // Jump target from ALUOut; ALU forms old PC + 4 for the link write.
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_write  = 1'b1;
        state_d   = S_ALUWB;
      end
      S_BEQ: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b01;
        pc_write  = zero;
        retire    = 1'b1;
        state_d   = S_FETCH;
      end
`ifdef MC_ILLEGAL_HALT_EN
      S_HALT: begin
        state_d = S_HALT;
      end
`endif
      default: begin
        state_d = S_FETCH;
      end
    endcase

    if (reset) begin
      pc_write  = 1'b0;
      ir_write  = 1'b0;
      reg_write = 1'b0;
      mem_write = 1'b0;
      retire    = 1'b0;
    end
  end

endmodule
